// File: rtl/usr_pkg.sv
// usr_pkg: shared types and next-value logic for univ_shift_reg_p.
//   usr_mode_e  : 3-bit command code presented on the mode port
//   usr_state_e : burst sequencer state
//   usr_fn#(W)::usr_next : width-parameterised next-register-value helper
package usr_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'b000,
        SHR   = 3'b001,
        SHL   = 3'b010,
        LOAD  = 3'b011,
        ROR   = 3'b100,
        ROL   = 3'b101,
        ASR   = 3'b110,
        BURST = 3'b111
    } usr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_e;

    // A class wrapper is the only way SV-2012 lets a package function take
    // its vector width as a parameter; it holds no data, only this function.
    virtual class usr_fn #(parameter int W = 8);
        static function logic [W-1:0] usr_next(
            input logic [W-1:0] q,
            input usr_mode_e    mode,
            input logic         d_l,
            input logic         d_r,
            input logic [W-1:0] par_in
        );
            logic [W-1:0] nxt;
            nxt = q;
            case (mode)
                SHR:     nxt = {d_l, q[W-1:1]};
                SHL:     nxt = {q[W-2:0], d_r};
                LOAD:    nxt = par_in;
                ROR:     nxt = {q[0], q[W-1:1]};
                ROL:     nxt = {q[W-2:0], q[W-1]};
                ASR:     nxt = {q[W-1], q[W-1:1]};
                BURST:   nxt = par_in;
                default: nxt = q;
            endcase
            return nxt;
        endfunction
    endclass

endpackage

// File: rtl/univ_shift_reg_p.sv
// univ_shift_reg_p: WIDTH-generic universal shift register with a self-timed
// burst serialiser (load a word, shift it out LSB-first on so_r).
//
// Ports
//   clk, rst_n      : clock (rising edge), async active-low reset
//   en, mode[2:0]   : command valid / code, only sampled while busy=0
//   d_l, d_r        : serial inputs at MSB (SHR, BURST) and LSB (SHL)
//   par_in[WIDTH]   : parallel load word (LOAD, BURST)
//   q[WIDTH]        : register contents
//   so_r, so_l      : q[0] and q[WIDTH-1]
//   busy, done      : burst in progress / one-cycle completion pulse
//   shift_cnt[CW]   : saturating shifts since last LOAD or BURST start
//
// state | meaning
// IDLE  | accepting commands from en/mode
// SHIFT | burst in progress: SHR with d_l each cycle, inputs ignored
module univ_shift_reg_p
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             d_l,
    input  logic             d_r,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    shift_cnt
);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    usr_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    q_d = usr_fn#(WIDTH)::usr_next(q_q, usr_mode_e'(mode),
                                                   d_l, d_r, par_in);
                    case (usr_mode_e'(mode))
                        HOLD:  cnt_d = cnt_q;
                        LOAD:  cnt_d = '0;
                        BURST: begin
                            cnt_d   = '0;
                            state_d = SHIFT;
                        end
                        default: cnt_d = cnt_inc;
                    endcase
                end
            end
            SHIFT: begin
                q_d   = usr_fn#(WIDTH)::usr_next(q_q, SHR, d_l, 1'b0, par_in);
                cnt_d = cnt_inc;
                // This step brings the count to WIDTH: the last bit is out.
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q         = q_q;
    assign so_r      = q_q[0];
    assign so_l      = q_q[WIDTH-1];
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign shift_cnt = cnt_q;

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Testbench for univ_shift_reg_p at WIDTH=4: directed steps followed by
// randomized commands, compared against an integer reference model.
module tb_univ_shift_reg_p;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [2:0]   mode;
    logic         d_l;
    logic         d_r;
    logic [W-1:0] par_in;
    logic [W-1:0] q;
    logic         so_r;
    logic         so_l;
    logic         busy;
    logic         done;
    logic [CW-1:0] shift_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_q, m_cnt, m_left;
    bit m_busy, m_done;

    univ_shift_reg_p #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d_l(d_l), .d_r(d_r),
        .par_in(par_in), .q(q), .so_r(so_r), .so_l(so_l), .busy(busy),
        .done(done), .shift_cnt(shift_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_up(input int c);
        return (c + 1 > (1 << CW) - 1) ? c : c + 1;
    endfunction

    task automatic model_reset();
        m_q = 0; m_cnt = 0; m_left = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_step(input bit e, input int m, input int dl, input int dr, input int p);
        int top;
        top = 1 << (W - 1);
        m_done = 0;
        if (m_busy) begin
            m_q = (m_q >> 1) + dl * top;
            m_cnt = cnt_up(m_cnt);
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (e) begin
            case (m)
                1: begin m_q = (m_q >> 1) + dl * top;               m_cnt = cnt_up(m_cnt); end
                2: begin m_q = ((m_q * 2) % (1 << W)) + dr;         m_cnt = cnt_up(m_cnt); end
                3: begin m_q = p; m_cnt = 0; end
                4: begin m_q = (m_q >> 1) + (m_q % 2) * top;        m_cnt = cnt_up(m_cnt); end
                5: begin m_q = ((m_q * 2) % (1 << W)) + m_q / top;  m_cnt = cnt_up(m_cnt); end
                6: begin m_q = (m_q >> 1) + (m_q / top) * top;      m_cnt = cnt_up(m_cnt); end
                7: begin m_q = p; m_cnt = 0; m_busy = 1; m_left = W; end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    32'(q),         32'(m_q));
        chk({tag, ".busy"}, 32'(busy),      32'(m_busy));
        chk({tag, ".done"}, 32'(done),      32'(m_done));
        chk({tag, ".cnt"},  32'(shift_cnt), 32'(m_cnt));
        chk({tag, ".so_r"}, 32'(so_r),      32'(m_q % 2));
        chk({tag, ".so_l"}, 32'(so_l),      32'(m_q / (1 << (W - 1))));
    endtask

    // Apply inputs, take one rising edge, then compare 1 time unit later.
    task automatic tick(input string tag, input bit e, input logic [2:0] m,
                        input logic dl, input logic dr, input logic [W-1:0] p);
        en = e; mode = m; d_l = dl; d_r = dr; par_in = p;
        @(posedge clk);
        #1;
        model_step(e, int'(m), int'(dl), int'(dr), int'(p));
        check_all(tag);
    endtask

    // Asserts reset mid-cycle and expects outputs to clear before any edge.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".q"},    32'(q),         32'd0);
        chk({tag, ".busy"}, 32'(busy),      32'd0);
        chk({tag, ".done"}, 32'(done),      32'd0);
        chk({tag, ".cnt"},  32'(shift_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] bits;
        logic [W-1:0] dlw;
        int occ;
        bit saw_done;

        rst_n = 1'b1; en = 1'b0; mode = 3'd0; d_l = 1'b0; d_r = 1'b0; par_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.q",    32'(q),         32'd0);
        chk("rst.busy", 32'(busy),      32'd0);
        chk("rst.done", 32'(done),      32'd0);
        chk("rst.cnt",  32'(shift_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // basic modes
        tick("load", 1, 3'd3, 0, 0, 4'b1010);
        chk("load.q_const", 32'(q), 32'b1010);
        tick("shr",  1, 3'd1, 1, 0, 4'b0000);
        chk("shr.q_const", 32'(q), 32'b1101);
        tick("shl",  1, 3'd2, 0, 0, 4'b0000);
        chk("shl.q_const", 32'(q), 32'b1010);
        tick("hold", 1, 3'd0, 1, 1, 4'b1111);
        tick("en0",  0, 3'd3, 1, 1, 4'b1111);
        chk("en0.q_const", 32'(q), 32'b1010);

        // rotate / arithmetic from a fresh load
        tick("load2", 1, 3'd3, 0, 0, 4'b1010);
        tick("ror",   1, 3'd4, 1, 1, 4'b0000);
        chk("ror.q_const", 32'(q), 32'b0101);
        tick("rol",   1, 3'd5, 0, 0, 4'b0000);
        chk("rol.q_const", 32'(q), 32'b1010);
        tick("asr1",  1, 3'd6, 0, 0, 4'b0000);
        chk("asr1.q_const", 32'(q), 32'b1101);
        tick("asr2",  1, 3'd6, 0, 0, 4'b0000);
        chk("asr2.q_const", 32'(q), 32'b1110);
        chk("asr2.cnt_const", 32'(shift_cnt), 32'd4);

        // saturation of shift_cnt
        for (int i = 0; i < 6; i++) tick("sat", 1, 3'd4, 0, 0, 4'b0000);
        chk("sat.cnt_const", 32'(shift_cnt), 32'd7);

        // BURST 1011, d_l=0
        bits = 4'b1011;
        tick("burst_e0", 1, 3'd7, 0, 0, bits);
        chk("burst.so_r_e0", 32'(so_r), 32'(bits[0]));
        occ = 1;
        for (int k = 1; k <= W; k++) begin
            tick("burst_ek", 0, 3'd0, 0, 0, 4'b0000);
            occ++;
            if (k < W) begin
                chk("burst.so_r_ek", 32'(so_r), 32'(bits[k]));
                chk("burst.busy_ek", 32'(busy), 32'd1);
                chk("burst.done_ek", 32'(done), 32'd0);
            end
        end
        chk("burst.done_end", 32'(done), 32'd1);
        chk("burst.busy_end", 32'(busy), 32'd0);
        chk("burst.q_end",    32'(q),    32'd0);
        chk("burst.cnt_end",  32'(shift_cnt), 32'd4);
        chk("burst.occupancy", 32'(occ), 32'(W + 1));
        tick("burst_after", 0, 3'd0, 0, 0, 4'b0000);
        chk("burst.done_once", 32'(done), 32'd0);

        // command while busy is ignored; back-to-back BURST at done cycle
        dlw = 4'b0110;
        tick("busy_e0", 1, 3'd7, 1, 0, 4'b1001);
        for (int k = 1; k <= W; k++) begin
            if (k == 3) tick("busy_cmd", 1, 3'd3, dlw[k-1], 1, 4'b1111);
            else        tick("busy_ek",  1, 3'd2, dlw[k-1], 1, 4'b1111);
        end
        chk("busy.q_dl",   32'(q),    32'(dlw));
        chk("busy.done",   32'(done), 32'd1);
        tick("b2b_e0", 1, 3'd7, 0, 0, 4'b0101);
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.q",    32'(q),    32'b0101);
        for (int k = 1; k <= W; k++) tick("b2b_ek", 0, 3'd0, 1, 0, 4'b0000);
        chk("b2b.q_end", 32'(q), 32'b1111);

        // reset mid-BURST
        tick("rmid_e0", 1, 3'd7, 1, 0, 4'b1100);
        tick("rmid_e1", 0, 3'd0, 1, 0, 4'b0000);
        tick("rmid_e2", 0, 3'd0, 1, 0, 4'b0000);
        async_reset("rmid");
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick("rmid_idle", 0, 3'd0, 1, 0, 4'b0000);
            if (done) saw_done = 1;
        end
        chk("rmid.no_done", 32'(saw_done), 32'd0);
        tick("fresh_e0", 1, 3'd7, 0, 0, 4'b0011);
        for (int k = 1; k <= W; k++) tick("fresh_ek", 0, 3'd0, 1, 0, 4'b0000);
        chk("fresh.done", 32'(done), 32'd1);
        chk("fresh.q",    32'(q),    32'b1111);

        // randomized commands against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rnd_rst");
            end
            tick("rnd", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
